// File: rtl/ddr_512b_adc_packer.sv
// ddr_512b_adc_packer
// Transmit-side packer for the DDR ADC stream. Each sample is a HEAD_WD head
// followed by a DATA_WD ADC word. NSLOT = DATA_WD/HEAD_WD samples are laid end
// to end (head in the low bits of each sample) and cut into NSLOT+1 beats of
// DATA_WD bits, with no gaps between beats.
// The upper part of each ADC word that does not fit in the current beat is kept
// right-aligned in r_resid. It starts the next beat.
// After NSLOT samples, r_resid holds the whole last ADC word. That word goes out
// as an extra beat that consumes no input.
// Optional build macro: ADC_PACKER_STAT_EN adds the 32-bit frame_cnt output.
// It counts completed frames and is cleared only by rst_n.
// Assumes NSLOT >= 2, and DATA_WD must be an exact multiple of HEAD_WD.
module ddr_512b_adc_packer #(
  parameter int DATA_WD = 512,
  parameter int HEAD_WD = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_rst,
  input  logic [HEAD_WD-1:0] s_head_data,
  input  logic [DATA_WD-1:0] s_adc_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic [DATA_WD-1:0] m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready
`ifdef ADC_PACKER_STAT_EN
  ,
  output logic [31:0]        frame_cnt
`endif
);

  localparam int NSLOT = DATA_WD / HEAD_WD;
  localparam int PH_W  = $clog2(NSLOT + 1);

  logic [PH_W-1:0]    r_phase;
  logic [DATA_WD-1:0] r_resid;
  logic [DATA_WD-1:0] r_tdata;
  logic               r_tvalid;

  logic               w_ld;
  logic               w_last;
  logic               w_accept;
  logic [DATA_WD-1:0] w_slot_beat  [NSLOT];
  logic [DATA_WD-1:0] w_slot_resid [NSLOT];
  logic [DATA_WD-1:0] w_sel_beat;
  logic [DATA_WD-1:0] w_sel_resid;

  assign w_ld     = ~r_tvalid | m_axis_tready;
  assign w_last   = (r_phase == PH_W'(NSLOT));
  assign s_ready  = w_ld & ~w_last & ~cfg_rst;
  assign w_accept = s_valid & s_ready;

  assign m_axis_tdata  = r_tdata;
  assign m_axis_tvalid = r_tvalid;

  // For each slot k, build the beat the incoming sample produces:
  // {adc low part, head, carried resid}. Also build the new residue, which is
  // the adc part that spills into the next beat.
  genvar gi;
  generate
    for (gi = 0; gi < NSLOT; gi++) begin : g_slot
      if (gi == 0) begin : g_first
        assign w_slot_beat[gi] = {s_adc_data[DATA_WD-HEAD_WD-1:0], s_head_data};
      end else if (gi == NSLOT - 1) begin : g_final
        assign w_slot_beat[gi] = {s_head_data, r_resid[HEAD_WD*gi-1:0]};
      end else begin : g_mid
        assign w_slot_beat[gi] = {s_adc_data[DATA_WD-HEAD_WD*(gi+1)-1:0],
                                  s_head_data,
                                  r_resid[HEAD_WD*gi-1:0]};
      end

      if (gi == NSLOT - 1) begin : g_full
        assign w_slot_resid[gi] = s_adc_data;
      end else begin : g_part
        assign w_slot_resid[gi] = {{(DATA_WD-HEAD_WD*(gi+1)){1'b0}},
                                   s_adc_data[DATA_WD-1:DATA_WD-HEAD_WD*(gi+1)]};
      end
    end
  endgenerate

  // Select the slot candidates for the current phase (unused in the flush phase)
  always_comb begin
    w_sel_beat  = w_slot_beat[0];
    w_sel_resid = w_slot_resid[0];
    for (int i = 0; i < NSLOT; i++) begin
      if (r_phase == PH_W'(i)) begin
        w_sel_beat  = w_slot_beat[i];
        w_sel_resid = w_slot_resid[i];
      end
    end
  end

  // Phase, residue and output beat registers; cfg_rst drops any partial frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= '0;
      r_resid  <= '0;
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (cfg_rst) begin
      r_phase  <= '0;
      r_resid  <= '0;
      r_tvalid <= 1'b0;
    end else if (w_ld) begin
      if (w_last) begin
        r_tdata  <= r_resid;
        r_tvalid <= 1'b1;
        r_phase  <= '0;
        r_resid  <= '0;
      end else if (s_valid) begin
        r_tdata  <= w_sel_beat;
        r_resid  <= w_sel_resid;
        r_tvalid <= 1'b1;
        r_phase  <= r_phase + PH_W'(1);
      end else begin
        r_tvalid <= 1'b0;
      end
    end
  end

`ifdef ADC_PACKER_STAT_EN
  logic [31:0] r_frame_cnt;

  assign frame_cnt = r_frame_cnt;

  // Count flush beats (one per completed frame); cfg_rst does not clear it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
    end else if (!cfg_rst && w_ld && w_last) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end
`endif

endmodule
